pool2d_ctrl: RTL
================

Name: pool2d_ctrl

Overview:
- Controller and row buffer that completes 2x2 max-pooling around the existing horizontal pair-max stage.
- Drives that stage's en_maxpool and consumes its horizontally pooled stream.
- Even rows: the horizontally pooled samples are stored in a row buffer.
- Odd rows: each sample is compared against the stored sample from the same column, and the vertical max is emitted.
- Frames are sequenced by a start/busy/done handshake; a bypass mode passes the stream through when pooling is disabled.

Parameters:
DWIDTH, 20, sample width (matches the pooling datapath)
MAX_COLS, 64, row buffer depth (max horizontally pooled samples per row)
CWIDTH, 7, width of cfg_cols and the column counter (must hold MAX_COLS)
RWIDTH, 8, width of cfg_rows and the row counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state registers
start  input  1  single-cycle frame start, sampled only in IDLE
cfg_en_pool  input  1  1 = 2x2 pooling, 0 = bypass; latched at start
cfg_cols  input  CWIDTH  samples per row arriving on data_in; latched at start
cfg_rows  input  RWIDTH  rows per frame on data_in; latched at start
data_in  input  DWIDTH  sample from the horizontal pooling stage (unsigned)
valid_in  input  1  data_in qualifier
en_maxpool  output  1  enable to the horizontal pooling stage
data_out  output  DWIDTH  pooled or bypassed sample
valid_out  output  1  data_out qualifier
busy  output  1  high from the cycle after accepted start through the DONE state
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (asynchronous, active-high): every register clears; the FSM goes to IDLE.
  - Output values in reset: en_maxpool=0, data_out=0, valid_out=0, busy=0, done=0.
  - Counters clear. Row buffer contents are not reset; every location is written before it is read.
- Reset mid-frame aborts the frame immediately, with no done pulse.
- FSM states: IDLE, EVEN, ODD, BYPASS, DONE.
- IDLE:
  - start=1 latches the config.
  - Latched cols is min(cfg_cols, MAX_COLS).
  - Next state:
    - DONE if latched cols==0 or cfg_rows==0.
    - Otherwise BYPASS if cfg_en_pool=0.
    - Otherwise EVEN.
  - valid_in is ignored in IDLE. start is ignored outside IDLE.
- Counters: col counts valid_in beats 0..cols-1; row counts 0..rows-1.
  - On a beat with col==cols-1: col wraps to 0 and row increments.
  - All transitions below happen on that wrap beat.
- EVEN:
  - Each valid_in writes data_in to buf[col]; no output.
  - On the row wrap: go to ODD if row+1<rows.
  - If rows is odd, the final unpaired row is consumed and discarded (floor semantics), and the FSM goes to DONE.
- ODD:
  - Each valid_in registers data_out = (buf[col] > data_in) ? buf[col] : data_in, as an unsigned compare, with valid_out=1 on the next cycle. Latency is 1 cycle.
  - On the row wrap: go to DONE if row+1==rows, else go to EVEN.
- BYPASS:
  - Each valid_in registers data_out=data_in and valid_out=1 on the next cycle.
  - After rows*cols beats, go to DONE.
- DONE: lasts one cycle with done=1 and busy=1; then IDLE.
  - A start in the DONE cycle is ignored; start is accepted again in IDLE the next cycle.
- valid_out is 0 on every cycle without a qualifying beat in the previous cycle. data_out holds its last value when valid_out=0.
- en_maxpool = latched cfg_en_pool while in EVEN/ODD/BYPASS, else 0.
  - The upstream toggle therefore restarts at each frame.
  - Gaps in valid_in are allowed anywhere; the counters advance only on valid_in.
- Output rate in pool mode: floor(rows/2)*cols outputs per frame.
- Buffer read is same-cycle (register array). No read/write collision can occur, because EVEN only writes and ODD only reads.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> all outputs 0 immediately; start not given -> valid_in pulses produce no valid_out.
- Pool 4x2: cols=2, rows=4, en_pool=1.
  - Stimulus: row0 {5,9}, row1 {7,3}, row2 {1,0xFFFFF}, row3 {2,0xFFFFE}.
  - Required: valid_out exactly 4 times, data {7,9,2,0xFFFFF}, each one cycle after its row1/row3 beat; done one cycle after DONE entry; busy spans the frame.
- Bypass: en_pool=0, cols=3, rows=2, six beats 1..6 with random valid_in gaps -> data_out 1..6, each one cycle later; en_maxpool=0 throughout; single done pulse.
- Odd rows and clamp: en_pool=1, cols=70 (clamped to 64), rows=3.
  - Required: 64 outputs after row 1; row 2 consumed with no output; done after the 192nd beat.
- Zero config: start with cols=0 -> done pulses in the cycle after start with no outputs; start during busy is ignored and config is unchanged.
- Abort: reset after 5 beats of row 1 in a 2x2-pooled 4x4 frame -> no done; a new frame afterwards produces correct results from a clean col/row of 0.

Source files
------------

// File: rtl/pool2d_ctrl_if.sv
// Stream and frame-control bundle between the 2x2 pooling controller and its
// surroundings: frame start/config, the horizontally pooled input stream, the
// pooled output stream and the frame status flags.
interface pool2d_ctrl_if #(
    parameter int unsigned DWIDTH = 20,
    parameter int unsigned CWIDTH = 7,
    parameter int unsigned RWIDTH = 8
);
    logic              start;
    logic              cfg_en_pool;
    logic [CWIDTH-1:0] cfg_cols;
    logic [RWIDTH-1:0] cfg_rows;
    logic [DWIDTH-1:0] data_in;
    logic              valid_in;
    logic              en_maxpool;
    logic [DWIDTH-1:0] data_out;
    logic              valid_out;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_en_pool, cfg_cols, cfg_rows, data_in, valid_in,
        input  en_maxpool, data_out, valid_out, busy, done
    );

    modport slave (
        input  start, cfg_en_pool, cfg_cols, cfg_rows, data_in, valid_in,
        output en_maxpool, data_out, valid_out, busy, done
    );
endinterface

// File: rtl/pool2d_ctrl.sv
// 2x2 max-pooling controller: wraps the horizontal pair-max stage, buffers
// even rows, emits the vertical max on odd rows, or bypasses the stream.
module pool2d_ctrl #(
    parameter int unsigned DWIDTH   = 20,
    parameter int unsigned MAX_COLS = 64,
    parameter int unsigned CWIDTH   = 7,
    parameter int unsigned RWIDTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    pool2d_ctrl_if.slave bus
);
    localparam int unsigned AWIDTH = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [CWIDTH-1:0] MAX_COLS_C = CWIDTH'(MAX_COLS);

    typedef enum logic [2:0] {
        IDLE,
        EVEN,
        ODD,
        BYPASS,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CWIDTH-1:0] cols_q;
    logic [RWIDTH-1:0] rows_q;
    logic              en_pool_q;
    logic [CWIDTH-1:0] col;
    logic [RWIDTH-1:0] row;
    logic [DWIDTH-1:0] row_buf [MAX_COLS];
    logic [DWIDTH-1:0] data_q;
    logic              valid_q;

    logic              active;
    logic              beat;
    logic              col_wrap;
    logic              last_row;
    logic              accept;
    logic [CWIDTH-1:0] start_cols;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] stored;

    // Beat qualification, counter wrap detection and buffer read port
    always_comb begin
        active     = (state == EVEN) || (state == ODD) || (state == BYPASS);
        beat       = active && bus.valid_in;
        col_wrap   = (col == cols_q - 1'b1);
        last_row   = (row == rows_q - 1'b1);
        accept     = (state == IDLE) && bus.start;
        start_cols = (bus.cfg_cols > MAX_COLS_C) ? MAX_COLS_C : bus.cfg_cols;
        addr       = col[AWIDTH-1:0];
        stored     = row_buf[addr];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; all row transitions happen on the column-wrap beat
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if ((start_cols == '0) || (bus.cfg_rows == '0)) begin
                        state_next = DONE;
                    end else if (!bus.cfg_en_pool) begin
                        state_next = BYPASS;
                    end else begin
                        state_next = EVEN;
                    end
                end
            end
            EVEN: begin
                // A final unpaired row is consumed and dropped
                if (beat && col_wrap) begin
                    state_next = last_row ? DONE : ODD;
                end
            end
            ODD: begin
                if (beat && col_wrap) begin
                    state_next = last_row ? DONE : EVEN;
                end
            end
            BYPASS: begin
                if (beat && col_wrap && last_row) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame configuration latch and column/row counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cols_q    <= '0;
            rows_q    <= '0;
            en_pool_q <= 1'b0;
            col       <= '0;
            row       <= '0;
        end else if (accept) begin
            cols_q    <= start_cols;
            rows_q    <= bus.cfg_rows;
            en_pool_q <= bus.cfg_en_pool;
            col       <= '0;
            row       <= '0;
        end else if (beat) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Even-row storage; every location is written before an odd row reads it
    always_ff @(posedge clk) begin
        if (beat && (state == EVEN)) begin
            row_buf[addr] <= bus.data_in;
        end
    end

    // Registered output: vertical max on odd rows, passthrough in bypass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (beat && (state == ODD)) begin
                data_q  <= (stored > bus.data_in) ? stored : bus.data_in;
                valid_q <= 1'b1;
            end else if (beat && (state == BYPASS)) begin
                data_q  <= bus.data_in;
                valid_q <= 1'b1;
            end
        end
    end

    // Status and upstream enable derived from the current state
    always_comb begin
        bus.data_out   = data_q;
        bus.valid_out  = valid_q;
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.en_maxpool = active && en_pool_q;
    end
endmodule
